// File: rtl/toy_cpu_mc.sv
// Small multi-cycle CPU core: register file, single-cycle ALU ops and an
// iterative shift-add multiplier that stalls issue while it runs.
module toy_cpu_mc #(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 8,
  localparam int AW      = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        opcode,
  input  logic [AW-1:0]     src_a,
  input  logic [AW-1:0]     src_b,
  input  logic [AW-1:0]     dest,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] out,
  output logic              res_valid,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] MUL_LAST = CW'(DATA_W - 1);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_XORI = 3'd6;
  localparam logic [2:0] OP_LDI  = 3'd7;

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_acc;
  logic [AW-1:0]     r_mul_dest;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_out;
  logic              r_res_valid;
  logic              r_flag_z;
  logic              r_flag_c;

  logic [DATA_W-1:0] w_rd [REG_CNT];
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_opnd;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_has_res;
  logic              w_accept;
  logic              w_mul_last;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_c;

  // Register 0 has no storage, so it reads zero and silently drops writes.
  assign w_rd[0] = '0;
  for (genvar gi = 1; gi < REG_CNT; gi++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_wr_en && (w_wr_addr == AW'(gi))) begin
        r_q <= w_wr_data;
      end
    end
    assign w_rd[gi] = r_q;
  end

  assign w_a    = w_rd[src_a];
  assign w_b    = w_rd[src_b];
  assign w_opnd = ((opcode == OP_ADD) || (opcode == OP_SUB)) ? w_b : imm;
  assign w_sum  = {1'b0, w_a} + {1'b0, w_opnd};
  assign w_diff = {1'b0, w_a} - {1'b0, w_opnd};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: begin w_res = w_sum[DATA_W-1:0];  w_c = w_sum[DATA_W];  end
      OP_SUB, OP_SUBI: begin w_res = w_diff[DATA_W-1:0]; w_c = w_diff[DATA_W]; end
      OP_XORI:         w_res = w_a ^ imm;
      OP_LDI:          w_res = imm;
      default:         w_res = '0;
    endcase
  end

  assign w_has_res  = (opcode != OP_NOP) && (opcode != OP_MUL);
  assign op_ready   = (r_state == S_IDLE);
  assign w_accept   = op_valid && op_ready;
  assign w_mul_last = (r_state == S_MUL_BUSY) && (r_cnt == MUL_LAST);
  assign w_acc_next = r_mul_b[0] ? (r_acc + r_mul_a) : r_acc;

  // Single write port shared by ALU ops and multiply completion; they never coincide.
  assign w_wr_en   = (w_accept && w_has_res) || w_mul_last;
  assign w_wr_addr = w_mul_last ? r_mul_dest : dest;
  assign w_wr_data = w_mul_last ? w_acc_next : w_res;
  assign w_wr_c    = w_mul_last ? 1'b0 : w_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
      r_mul_dest  <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_res_valid <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
    end else begin
      r_res_valid <= w_wr_en;
      if (w_wr_en) begin
        r_out    <= w_wr_data;
        r_flag_z <= (w_wr_data == '0);
        r_flag_c <= w_wr_c;
      end
      if (r_state == S_IDLE) begin
        if (w_accept && (opcode == OP_MUL)) begin
          r_mul_a    <= w_a;
          r_mul_b    <= w_b;
          r_acc      <= '0;
          r_mul_dest <= dest;
          r_cnt      <= '0;
          r_state    <= S_MUL_BUSY;
        end
      end else begin
        r_acc   <= w_acc_next;
        r_mul_a <= {r_mul_a[DATA_W-2:0], 1'b0};
        r_mul_b <= {1'b0, r_mul_b[DATA_W-1:1]};
        r_cnt   <= r_cnt + CW'(1);
        if (r_cnt == MUL_LAST) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign out       = r_out;
  assign res_valid = r_res_valid;
  assign flag_z    = r_flag_z;
  assign flag_c    = r_flag_c;

endmodule

// File: tb/tb_toy_cpu_mc.sv
// Directed bench for toy_cpu_mc: 8-bit instance for hand-computed vectors,
// 16-bit instance for a continuous issue stream against a reference model.
module tb_toy_cpu_mc;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] ADDI = 3'd2;
  localparam logic [2:0] SUBI = 3'd4;
  localparam logic [2:0] MUL  = 3'd5;
  localparam logic [2:0] LDI  = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       op_valid, op_ready, res_valid, flag_z, flag_c;
  logic [2:0] opcode, src_a, src_b, dest;
  logic [7:0] imm, out;

  logic        op_valid_w, op_ready_w, res_valid_w, flag_z_w, flag_c_w;
  logic [2:0]  opcode_w;
  logic [3:0]  src_a_w, src_b_w, dest_w;
  logic [15:0] imm_w, out_w;

  int n_checks = 0;
  int n_pass   = 0;

  toy_cpu_mc #(.DATA_W(8), .REG_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .src_a(src_a), .src_b(src_b), .dest(dest), .imm(imm),
    .out(out), .res_valid(res_valid), .flag_z(flag_z), .flag_c(flag_c)
  );

  toy_cpu_mc #(.DATA_W(16), .REG_CNT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid_w), .op_ready(op_ready_w),
    .opcode(opcode_w), .src_a(src_a_w), .src_b(src_b_w), .dest(dest_w), .imm(imm_w),
    .out(out_w), .res_valid(res_valid_w), .flag_z(flag_z_w), .flag_c(flag_c_w)
  );

  task automatic drive(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [7:0] im);
    opcode = o; dest = d; src_a = a; src_b = b; imm = im; op_valid = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [7:0] im);
    @(negedge clk);
    drive(o, d, a, b, im);
    @(negedge clk);
    op_valid = 1'b0;
    $display("op=%0d rd=%0d ra=%0d rb=%0d imm=%0d -> out=%0d z=%0b c=%0b rv=%0b",
             o, d, a, b, im, out, flag_z, flag_c, res_valid);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op_valid = 1'b0; opcode = NOP; src_a = 0; src_b = 0; dest = 0; imm = 0;
    op_valid_w = 1'b0; opcode_w = NOP; src_a_w = 0; src_b_w = 0; dest_w = 0; imm_w = 0;
    #12;
    n_checks++;
    if ({out, res_valid, flag_z, flag_c, op_ready} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset8 got out=%0d rv=%0b z=%0b c=%0b rdy=%0b want 0 0 0 0 1",
               out, res_valid, flag_z, flag_c, op_ready);
    else n_pass++;
    n_checks++;
    if ({out_w, res_valid_w, flag_z_w, flag_c_w, op_ready_w} !== {16'd0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset16 got out=%0d rv=%0b z=%0b c=%0b rdy=%0b want 0 0 0 0 1",
               out_w, res_valid_w, flag_z_w, flag_c_w, op_ready_w);
    else n_pass++;
    // Release and offer an op in the same cycle: first posedge must accept it.
    @(negedge clk);
    rst_n = 1'b1;
    drive(LDI, 3'd7, 3'd0, 3'd0, 8'd9);
    @(negedge clk);
    op_valid = 1'b0;
    n_checks++;
    if ({res_valid, out} !== {1'b1, 8'd9})
      $display("FAIL first_accept got rv=%0b out=%0d want rv=1 out=9", res_valid, out);
    else n_pass++;
  endtask

  task automatic test_add_carry();
    do_op(LDI, 3'd1, 3'd0, 3'd0, 8'd200);
    n_checks++;
    if ({res_valid, out} !== {1'b1, 8'd200})
      $display("FAIL ldi_200 got rv=%0b out=%0d want rv=1 out=200", res_valid, out);
    else n_pass++;
    do_op(ADDI, 3'd2, 3'd1, 3'd0, 8'd100);
    n_checks++;
    if ({res_valid, out, flag_z, flag_c} !== {1'b1, 8'd44, 1'b0, 1'b1})
      $display("FAIL addi_carry got rv=%0b out=%0d z=%0b c=%0b want 1 44 0 1",
               res_valid, out, flag_z, flag_c);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0)
      $display("FAIL rv_pulse got rv=%0b want 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_sub();
    do_op(LDI, 3'd3, 3'd0, 3'd0, 8'd5);
    do_op(SUBI, 3'd4, 3'd3, 3'd0, 8'd5);
    n_checks++;
    if ({res_valid, out, flag_z, flag_c} !== {1'b1, 8'd0, 1'b1, 1'b0})
      $display("FAIL subi_zero got rv=%0b out=%0d z=%0b c=%0b want 1 0 1 0",
               res_valid, out, flag_z, flag_c);
    else n_pass++;
    do_op(SUBI, 3'd4, 3'd3, 3'd0, 8'd6);
    n_checks++;
    if ({res_valid, out, flag_z, flag_c} !== {1'b1, 8'd255, 1'b0, 1'b1})
      $display("FAIL subi_borrow got rv=%0b out=%0d z=%0b c=%0b want 1 255 0 1",
               res_valid, out, flag_z, flag_c);
    else n_pass++;
  endtask

  task automatic test_r0();
    do_op(LDI, 3'd0, 3'd0, 3'd0, 8'd77);
    n_checks++;
    if ({res_valid, out, flag_z} !== {1'b1, 8'd77, 1'b0})
      $display("FAIL ldi_r0 got rv=%0b out=%0d z=%0b want 1 77 0", res_valid, out, flag_z);
    else n_pass++;
    do_op(ADD, 3'd6, 3'd0, 3'd0, 8'd0);
    n_checks++;
    if ({res_valid, out, flag_z, flag_c} !== {1'b1, 8'd0, 1'b1, 1'b0})
      $display("FAIL r0_zero got rv=%0b out=%0d z=%0b c=%0b want 1 0 1 0",
               res_valid, out, flag_z, flag_c);
    else n_pass++;
    do_op(NOP, 3'd6, 3'd1, 3'd1, 8'd3);
    n_checks++;
    if ({res_valid, out, flag_z} !== {1'b0, 8'd0, 1'b1})
      $display("FAIL nop got rv=%0b out=%0d z=%0b want 0 0 1", res_valid, out, flag_z);
    else n_pass++;
  endtask

  task automatic test_mul();
    int busy;
    logic rv_early;
    do_op(LDI, 3'd1, 3'd0, 3'd0, 8'd13);
    do_op(LDI, 3'd2, 3'd0, 3'd0, 8'd11);
    do_op(MUL, 3'd5, 3'd1, 3'd2, 8'd0);
    busy = 0; rv_early = 1'b0;
    while (!op_ready && busy < 40) begin
      rv_early |= res_valid;
      busy++;
      @(negedge clk);
    end
    n_checks++;
    if ({busy, rv_early} !== {32'd8, 1'b0})
      $display("FAIL mul_busy got busy=%0d early_rv=%0b want 8 0", busy, rv_early);
    else n_pass++;
    n_checks++;
    if ({res_valid, out, flag_z, flag_c} !== {1'b1, 8'd143, 1'b0, 1'b0})
      $display("FAIL mul_13x11 got rv=%0b out=%0d z=%0b c=%0b want 1 143 0 0",
               res_valid, out, flag_z, flag_c);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0)
      $display("FAIL mul_rv_pulse got rv=%0b want 0", res_valid);
    else n_pass++;
    // 16*16 wraps to zero; an LDI offered while busy must be ignored.
    do_op(LDI, 3'd3, 3'd0, 3'd0, 8'd16);
    do_op(MUL, 3'd5, 3'd3, 3'd3, 8'd0);
    drive(LDI, 3'd7, 3'd0, 3'd0, 8'd99);
    repeat (4) @(negedge clk);
    op_valid = 1'b0;
    busy = 0;
    while (!op_ready && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    n_checks++;
    if ({busy < 40, res_valid, out, flag_z, flag_c} !== {1'b1, 1'b1, 8'd0, 1'b1, 1'b0})
      $display("FAIL mul_16x16 got rv=%0b out=%0d z=%0b c=%0b want 1 0 1 0",
               res_valid, out, flag_z, flag_c);
    else n_pass++;
    do_op(ADD, 3'd6, 3'd7, 3'd0, 8'd0);
    n_checks++;
    if (out !== 8'd9)
      $display("FAIL busy_ignore got r7=%0d want 9", out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(LDI, 3'd1, 3'd0, 3'd0, 8'd7);
    @(negedge clk);
    n_checks++;
    if ({res_valid, out} !== {1'b1, 8'd7})
      $display("FAIL b2b_1 got rv=%0b out=%0d want 1 7", res_valid, out);
    else n_pass++;
    drive(ADDI, 3'd2, 3'd1, 3'd0, 8'd1);
    @(negedge clk);
    n_checks++;
    if ({res_valid, out} !== {1'b1, 8'd8})
      $display("FAIL b2b_2 got rv=%0b out=%0d want 1 8", res_valid, out);
    else n_pass++;
    drive(ADD, 3'd3, 3'd2, 3'd2, 8'd0);
    @(negedge clk);
    op_valid = 1'b0;
    n_checks++;
    if ({res_valid, out} !== {1'b1, 8'd16})
      $display("FAIL b2b_3 got rv=%0b out=%0d want 1 16", res_valid, out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0)
      $display("FAIL b2b_end got rv=%0b want 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    logic rv_seen;
    do_op(LDI, 3'd1, 3'd0, 3'd0, 8'd13);
    do_op(LDI, 3'd2, 3'd0, 3'd0, 8'd11);
    do_op(MUL, 3'd5, 3'd1, 3'd2, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out, res_valid, op_ready, flag_z, flag_c} !== {8'd0, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_rst got out=%0d rv=%0b rdy=%0b z=%0b c=%0b want 0 0 1 0 0",
               out, res_valid, op_ready, flag_z, flag_c);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      rv_seen |= res_valid;
    end
    n_checks++;
    if ({rv_seen, op_ready} !== {1'b0, 1'b1})
      $display("FAIL abort_mul got rv_seen=%0b rdy=%0b want 0 1", rv_seen, op_ready);
    else n_pass++;
    do_op(ADD, 3'd6, 3'd5, 3'd0, 8'd0);
    n_checks++;
    if ({out, flag_z} !== {8'd0, 1'b1})
      $display("FAIL dest_kept got r5=%0d z=%0b want 0 1", out, flag_z);
    else n_pass++;
  endtask

  task automatic test_stream16();
    logic [15:0] m_regs [16];
    logic [15:0] ea, eb, op2, eo, ro;
    logic [31:0] prod;
    logic [16:0] t;
    logic        ez, ec, rc, hit;
    logic [2:0]  o;
    logic [3:0]  d, a, b;
    logic [15:0] im;
    int pend, n_acc, n_seen;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    pend = 0; n_acc = 0; n_seen = 0;
    eo = '0; ez = 1'b0; ec = 1'b0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      hit = (pend == 1);
      if (pend > 0) pend--;
      if (res_valid_w) n_seen++;
      n_checks++;
      if (res_valid_w !== hit || op_ready_w !== (pend == 0) ||
          (hit && {out_w, flag_z_w, flag_c_w} !== {eo, ez, ec}))
        $display("FAIL stream cyc=%0d got rv=%0b rdy=%0b out=%0d z=%0b c=%0b want rv=%0b rdy=%0b out=%0d z=%0b c=%0b",
                 i, res_valid_w, op_ready_w, out_w, flag_z_w, flag_c_w, hit, pend == 0, eo, ez, ec);
      else n_pass++;
      o  = 3'($urandom_range(0, 7));
      d  = 4'($urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      im = 16'($urandom_range(0, 65535));
      opcode_w = o; dest_w = d; src_a_w = a; src_b_w = b; imm_w = im;
      op_valid_w = (i < 380);
      if (pend == 0 && i < 380) begin
        ea  = m_regs[a];
        eb  = m_regs[b];
        op2 = (o == ADD || o == 3'd3) ? eb : im;
        rc  = 1'b0;
        case (o)
          3'd1, 3'd2: begin t = {1'b0, ea} + {1'b0, op2}; ro = t[15:0]; rc = t[16]; end
          3'd3, 3'd4: begin ro = ea - op2; rc = (ea < op2); end
          3'd5:       begin prod = ea * eb; ro = prod[15:0]; end
          3'd6:       ro = ea ^ im;
          default:    ro = im;
        endcase
        if (o != NOP) begin
          eo = ro; ez = (ro == 16'd0); ec = rc;
          if (d != 4'd0) m_regs[d] = ro;
          n_acc++;
          pend = (o == MUL) ? 17 : 1;
        end
        $display("stream cyc=%0d op=%0d rd=%0d ra=%0d rb=%0d imm=%0d expect=%0d", i, o, d, a, b, im, ro);
      end
    end
    n_checks++;
    if (n_seen !== n_acc)
      $display("FAIL stream_count got results=%0d want %0d", n_seen, n_acc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_r0();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_stream16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
